// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: two write ports, two read ports, clear request and busy status.
interface regfile_param_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              clear;
    logic              wr0_en;
    logic              wr1_en;
    logic [ADDR_W-1:0] wr0_addr;
    logic [ADDR_W-1:0] wr1_addr;
    logic [WIDTH-1:0]  wr0_data;
    logic [WIDTH-1:0]  wr1_data;
    logic [ADDR_W-1:0] rd0_addr;
    logic [ADDR_W-1:0] rd1_addr;
    logic [WIDTH-1:0]  rd0_data;
    logic [WIDTH-1:0]  rd1_data;
    logic              busy;

    modport master (
        output clear, wr0_en, wr1_en, wr0_addr, wr1_addr, wr0_data, wr1_data,
               rd0_addr, rd1_addr,
        input  rd0_data, rd1_data, busy
    );

    modport slave (
        input  clear, wr0_en, wr1_en, wr0_addr, wr1_addr, wr0_data, wr1_data,
               rd0_addr, rd1_addr,
        output rd0_data, rd1_data, busy
    );
endinterface

// File: rtl/regfile_param.sv
// 2-write/2-read register file with a hardware clear sweep (also run out of reset).
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data onto matching read ports.
module regfile_param #(
    parameter int unsigned       WIDTH       = 32,
    parameter int unsigned       ADDR_W      = 5,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int unsigned       ZERO_REG    = 1
) (
    input  logic              clk,
    input  logic              reset,
    regfile_param_if.slave    bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  rd0_c, rd1_c;

    // Sweep control: ptr walks 0..DEPTH-1, one entry per edge while in CLEAR.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == CLEAR) begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                state_d = IDLE;
            end
        end else if (bus.clear) begin
            state_d = CLEAR;
            ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Storage: sweep owns the array in CLEAR; port 1 is written last so it wins on collisions.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem_q[ptr_q] <= RESET_VALUE;
            end else begin
                if (bus.wr0_en) mem_q[bus.wr0_addr] <= bus.wr0_data;
                if (bus.wr1_en) mem_q[bus.wr1_addr] <= bus.wr1_data;
            end
        end
    end

    always_comb begin
        rd0_c = mem_q[bus.rd0_addr];
        rd1_c = mem_q[bus.rd1_addr];
`ifdef REGFILE_BYPASS_EN
        if (state_q == IDLE) begin
            if (bus.wr1_en && (bus.wr1_addr == bus.rd0_addr)) begin
                rd0_c = bus.wr1_data;
            end else if (bus.wr0_en && (bus.wr0_addr == bus.rd0_addr)) begin
                rd0_c = bus.wr0_data;
            end
            if (bus.wr1_en && (bus.wr1_addr == bus.rd1_addr)) begin
                rd1_c = bus.wr1_data;
            end else if (bus.wr0_en && (bus.wr0_addr == bus.rd1_addr)) begin
                rd1_c = bus.wr0_data;
            end
        end
`else
`endif
        // Hardwired zero entry overrides storage and any forwarded data.
        if ((ZERO_REG != 0) && (bus.rd0_addr == '0)) rd0_c = '0;
        if ((ZERO_REG != 0) && (bus.rd1_addr == '0)) rd1_c = '0;
    end

    assign bus.rd0_data = rd0_c;
    assign bus.rd1_data = rd1_c;
    assign bus.busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param (default parameters).
module tb_regfile_param;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   n;

    regfile_param_if #(.WIDTH(32), .ADDR_W(5)) bus ();

    regfile_param #(
        .WIDTH(32), .ADDR_W(5), .RESET_VALUE(32'h0), .ZERO_REG(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.clear    = 1'b0;
        bus.wr0_en   = 1'b0;
        bus.wr1_en   = 1'b0;
        bus.wr0_addr = '0;
        bus.wr1_addr = '0;
        bus.wr0_data = '0;
        bus.wr1_data = '0;
    endtask

    task automatic wait_idle(input int start, output int cnt);
        cnt = start;
        while (bus.busy === 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_bus();
        bus.rd0_addr = '0;
        bus.rd1_addr = '0;

        // Reset and power-up sweep
        tick();
        chk("busy_in_reset", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        wait_idle(0, n);
        chk("reset_sweep_len", 32'(n), 32'd32);
        chk("busy_after_sweep", 32'(bus.busy), 32'd0);
        for (int i = 1; i < 32; i++) begin
            bus.rd0_addr = 5'(i);
            #1;
            chk($sformatf("cleared_%0d", i), bus.rd0_data, 32'h0);
        end

        // Basic write / zero register
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd5; bus.wr0_data = 32'hDEADBEEF;
        tick();
        idle_bus();
        bus.rd0_addr = 5'd5; bus.rd1_addr = 5'd0;
        #1;
        chk("wr0_addr5", bus.rd0_data, 32'hDEADBEEF);
        chk("rd1_zero", bus.rd1_data, 32'h0);

        // Same-address collision: port 1 wins
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd7; bus.wr0_data = 32'h11111111;
        bus.wr1_en = 1'b1; bus.wr1_addr = 5'd7; bus.wr1_data = 32'h22222222;
        tick();
        idle_bus();
        bus.rd0_addr = 5'd7;
        #1;
        chk("collision_addr7", bus.rd0_data, 32'h22222222);

        // Writes to entry 0 have no effect
        bus.wr1_en = 1'b1; bus.wr1_addr = 5'd0; bus.wr1_data = 32'hFFFFFFFF;
        tick();
        idle_bus();
        bus.rd1_addr = 5'd0;
        #1;
        chk("zero_reg_write", bus.rd1_data, 32'h0);

        // Clear sweep drops writes and ignores a re-asserted clear
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd3; bus.wr0_data = 32'hAAAA5555;
        tick();
        idle_bus();
        bus.clear = 1'b1;
        tick();
        chk("busy_after_clear", 32'(bus.busy), 32'd1);
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd3; bus.wr0_data = 32'h12345678;
        tick();
        tick();
        bus.rd0_addr = 5'd3; bus.rd1_addr = 5'd5;
        #1;
        chk("mid_sweep_e3_kept", bus.rd0_data, 32'hAAAA5555);
        chk("mid_sweep_e5_kept", bus.rd1_data, 32'hDEADBEEF);
        tick();
        idle_bus();
        wait_idle(3, n);
        chk("clear_sweep_len", 32'(n), 32'd32);
        bus.rd0_addr = 5'd3; bus.rd1_addr = 5'd5;
        #1;
        chk("e3_after_clear", bus.rd0_data, 32'h0);
        chk("e5_after_clear", bus.rd1_data, 32'h0);

        // Reset mid-sweep restarts from 0
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd20; bus.wr0_data = 32'h5A5A5A5A;
        tick();
        idle_bus();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        bus.rd0_addr = 5'd20;
        #1;
        chk("e20_before_reset", bus.rd0_data, 32'h5A5A5A5A);
        reset = 1'b1;
        tick();
        chk("busy_mid_reset", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        wait_idle(0, n);
        chk("restart_sweep_len", 32'(n), 32'd32);
        chk("e20_after_restart", bus.rd0_data, 32'h0);

        // Same-cycle read of a location being written
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd9; bus.wr0_data = 32'h01234567;
        tick();
        bus.wr0_data = 32'hCAFEF00D;
        bus.rd0_addr = 5'd9;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("same_cycle_e9", bus.rd0_data, 32'hCAFEF00D);
`else
        chk("same_cycle_e9", bus.rd0_data, 32'h01234567);
`endif
        tick();
        idle_bus();
        #1;
        chk("e9_after_edge", bus.rd0_data, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
